// File: rtl/lat_pkg.sv
// Definitions shared by the per-lane latency accumulator and its report path.
// LIMIT_TIME_DEFAULT must stay in step with the accumulator's window setting.
package lat_pkg;

  localparam int LIMIT_TIME_DEFAULT = 50000;
  localparam int W                  = 32;
  localparam int SEQ_W              = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } rpt_state_t;

  typedef struct packed {
    logic [W-1:0]     avg;
    logic [W-1:0]     total;
    logic [W-1:0]     pkts;
    logic [SEQ_W-1:0] seq;
  } report_t;

endpackage

// File: rtl/delay_avg_reporter_if.sv
// Report path between the average-delay reporter (master) and the host (slave).
interface delay_avg_reporter_if;
  import lat_pkg::*;

  logic             rpt_valid;
  logic             rpt_ready;
  logic [W-1:0]     rpt_avg;
  logic [W-1:0]     rpt_total;
  logic [W-1:0]     rpt_pkts;
  logic [SEQ_W-1:0] rpt_seq;
  logic [SEQ_W-1:0] drop_cnt;
  logic             busy;

  modport master (
    output rpt_valid, rpt_avg, rpt_total, rpt_pkts, rpt_seq, drop_cnt, busy,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid, rpt_avg, rpt_total, rpt_pkts, rpt_seq, drop_cnt, busy,
    output rpt_ready
  );

endinterface

// File: rtl/serial_divider.sv
// Unsigned W/W restoring divider, one quotient bit per cycle, MSB first.
// done_o and quotient_o are valid during the W-th cycle after start_i.
module serial_divider
  import lat_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int               CNT_W     = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] it_cnt_q, it_cnt_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W:0]       rem_q, rem_d;
  logic [W:0]       trial_s;
  logic             fits_s;
  logic [W-1:0]     quo_next_s;

  // one restoring step plus load/advance control
  always_comb begin
    trial_s    = (rem_q << 1) | {{W{1'b0}}, dvd_q[W-1]};
    fits_s     = (trial_s >= {1'b0, dvs_q});
    quo_next_s = (quo_q << 1) | {{(W-1){1'b0}}, fits_s};
    run_d      = run_q;
    it_cnt_d   = it_cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    if (start_i) begin
      run_d    = 1'b1;
      it_cnt_d = {CNT_W{1'b0}};
      dvd_d    = dividend_i;
      dvs_d    = divisor_i;
      quo_d    = {W{1'b0}};
      rem_d    = {(W+1){1'b0}};
    end else if (run_q) begin
      dvd_d    = dvd_q << 1;
      quo_d    = quo_next_s;
      rem_d    = fits_s ? (trial_s - {1'b0, dvs_q}) : trial_s;
      it_cnt_d = it_cnt_q + CNT_W'(1);
      if (it_cnt_q == LAST_STEP) begin
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // divider state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      it_cnt_q <= {CNT_W{1'b0}};
      dvd_q    <= {W{1'b0}};
      dvs_q    <= {W{1'b0}};
      quo_q    <= {W{1'b0}};
      rem_q    <= {(W+1){1'b0}};
    end else begin
      run_q    <= run_d;
      it_cnt_q <= it_cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

  // A zero divisor would otherwise yield all-ones.
  assign done_o     = run_q && (it_cnt_q == LAST_STEP);
  assign quotient_o = (dvs_q == {W{1'b0}}) ? {W{1'b0}} : quo_next_s;

endmodule

// File: rtl/delay_avg_reporter.sv
// Snapshots window delay/packet totals at each window end, divides them serially
// and presents {avg, total, pkts, seq} to the host over a valid/ready handshake.
module delay_avg_reporter
  import lat_pkg::*;
#(
  parameter int LIMIT_TIME = LIMIT_TIME_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          count,
  input  logic [W-1:0]          pktDelay,
  input  logic [W-1:0]          pktCount,
  delay_avg_reporter_if.master  rpt
);

  localparam logic [W-1:0] LAST_COUNT = W'(LIMIT_TIME);

  rpt_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q;
  logic [SEQ_W-1:0] win_idx_q;
  logic [SEQ_W-1:0] drop_q;
  logic [W-1:0]     snap_total_q;
  logic [W-1:0]     snap_pkts_q;
  logic [SEQ_W-1:0] snap_seq_q;
  report_t          rpt_q;
  logic             win_end_s;
  logic             capture_s;
  logic             drop_s;
  logic             publish_s;
  logic             div_done_s;
  logic [W-1:0]     quotient_s;

  assign win_end_s = (count == LAST_COUNT);

  serial_divider u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (capture_s),
    .dividend_i (pktDelay),
    .divisor_i  (pktCount),
    .done_o     (div_done_s),
    .quotient_o (quotient_s)
  );

  // next-state, capture, drop and publish decisions
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    capture_s = 1'b0;
    drop_s    = 1'b0;
    publish_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_end_s) begin
          capture_s = 1'b1;
          state_d   = DIV;
        end else begin
          state_d   = IDLE;
        end
      end
      DIV: begin
        drop_s = win_end_s;
        if (div_done_s) begin
          publish_s = 1'b1;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end else begin
          state_d   = DIV;
        end
      end
      HOLD: begin
        // A handshake on the window-end edge frees the slot, so nothing is lost.
        if (rpt.rpt_ready && win_end_s) begin
          capture_s = 1'b1;
          valid_d   = 1'b0;
          state_d   = DIV;
        end else if (rpt.rpt_ready) begin
          valid_d   = 1'b0;
          state_d   = IDLE;
        end else if (win_end_s) begin
          drop_s    = 1'b1;
        end else begin
          state_d   = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM, handshake and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      win_idx_q <= {SEQ_W{1'b0}};
      drop_q    <= {SEQ_W{1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
      if (win_end_s) begin
        win_idx_q <= win_idx_q + SEQ_W'(1);
      end
      if (drop_s && (drop_q != {SEQ_W{1'b1}})) begin
        drop_q <= drop_q + SEQ_W'(1);
      end
    end
  end

  // window snapshot and published report registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_total_q <= {W{1'b0}};
      snap_pkts_q  <= {W{1'b0}};
      snap_seq_q   <= {SEQ_W{1'b0}};
      rpt_q        <= '{avg: {W{1'b0}}, total: {W{1'b0}}, pkts: {W{1'b0}}, seq: {SEQ_W{1'b0}}};
    end else begin
      if (capture_s) begin
        snap_total_q <= pktDelay;
        snap_pkts_q  <= pktCount;
        snap_seq_q   <= win_idx_q;
      end
      if (publish_s) begin
        rpt_q.avg   <= (snap_pkts_q == {W{1'b0}}) ? {W{1'b0}} : quotient_s;
        rpt_q.total <= snap_total_q;
        rpt_q.pkts  <= snap_pkts_q;
        rpt_q.seq   <= snap_seq_q;
      end
    end
  end

  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_avg   = rpt_q.avg;
  assign rpt.rpt_total = rpt_q.total;
  assign rpt.rpt_pkts  = rpt_q.pkts;
  assign rpt.rpt_seq   = rpt_q.seq;
  assign rpt.drop_cnt  = drop_q;
  assign rpt.busy      = busy_q;

endmodule

// File: tb/tb_delay_avg_reporter.sv
// Self-checking bench for delay_avg_reporter: directed window scenarios followed by
// randomized totals and host readiness, compared cycle by cycle against a report model.
module tb_delay_avg_reporter;

  localparam logic [31:0] LIMIT   = 32'd200;
  localparam int          LATENCY = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] count;
  logic [31:0] pktDelay;
  logic [31:0] pktCount;

  delay_avg_reporter_if rpt_bus ();

  delay_avg_reporter #(.LIMIT_TIME(200)) dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .pktDelay (pktDelay),
    .pktCount (pktCount),
    .rpt      (rpt_bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc = 0;

  // Reference model: a pending (in-division) report and the report shown to the host.
  bit          m_valid;
  bit          m_pend;
  int unsigned m_due;
  logic [31:0] m_p_total, m_p_pkts;
  logic [15:0] m_p_seq;
  logic [31:0] m_avg, m_total, m_pkts;
  logic [15:0] m_seq, m_drops, m_win;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0; m_pend = 1'b0; m_due = 0;
    m_p_total = 32'd0; m_p_pkts = 32'd0; m_p_seq = 16'd0;
    m_avg = 32'd0; m_total = 32'd0; m_pkts = 32'd0; m_seq = 16'd0;
    m_drops = 16'd0; m_win = 16'd0;
  endfunction

  function automatic void model_capture();
    m_pend    = 1'b1;
    m_due     = cyc + LATENCY;
    m_p_total = pktDelay;
    m_p_pkts  = pktCount;
    m_p_seq   = m_win;
  endfunction

  // Effect of the upcoming clock edge; cyc is that edge's index.
  function automatic void model_edge(input bit win_end, input bit ready);
    if (m_valid && ready) begin
      m_valid = 1'b0;
      if (win_end) model_capture();
    end else if (win_end) begin
      if (m_valid || m_pend) begin
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
      end else begin
        model_capture();
      end
    end
    if (m_pend && (cyc == m_due)) begin
      m_pend  = 1'b0;
      m_valid = 1'b1;
      m_avg   = (m_p_pkts == 32'd0) ? 32'd0 : (m_p_total / m_p_pkts);
      m_total = m_p_total;
      m_pkts  = m_p_pkts;
      m_seq   = m_p_seq;
    end
    if (win_end) m_win = m_win + 16'd1;
  endfunction

  task automatic tick();
    if (reset) model_edge(count == LIMIT, rpt_bus.rpt_ready);
    else model_reset();
    @(posedge clk);
    #1;
    cyc++;
    check_val("valid", 32'(rpt_bus.rpt_valid), 32'(m_valid));
    check_val("busy",  32'(rpt_bus.busy),      32'(m_valid | m_pend));
    check_val("drops", 32'(rpt_bus.drop_cnt),  32'(m_drops));
    check_val("avg",   rpt_bus.rpt_avg,        m_avg);
    check_val("total", rpt_bus.rpt_total,      m_total);
    check_val("pkts",  rpt_bus.rpt_pkts,       m_pkts);
    check_val("seq",   32'(rpt_bus.rpt_seq),   32'(m_seq));
    count = (count == LIMIT) ? 32'd0 : count + 32'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge is a window end.
  task automatic run_to_window_end();
    for (int i = 0; (i < 210) && (count != LIMIT); i++) tick();
  endtask

  // Capture edge followed by the full division latency.
  task automatic capture_and_divide();
    run_to_window_end();
    tick();
    ticks(LATENCY - 1);
    check_val("lat_not_early", 32'(rpt_bus.rpt_valid), 32'd0);
    tick();
    check_val("lat_valid", 32'(rpt_bus.rpt_valid), 32'd1);
  endtask

  task automatic accept();
    rpt_bus.rpt_ready = 1'b1;
    tick();
    rpt_bus.rpt_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; count = 32'd0; pktDelay = 32'd0; pktCount = 32'd0;
    rpt_bus.rpt_ready = 1'b0;
    model_reset();
    ticks(3);
    check_val("rst_valid", 32'(rpt_bus.rpt_valid), 32'd0);
    check_val("rst_busy",  32'(rpt_bus.busy),      32'd0);
    reset = 1'b1;

    // Basic average with latency check
    pktDelay = 32'd1000; pktCount = 32'd7;
    capture_and_divide();
    check_val("t1_avg",   rpt_bus.rpt_avg,        32'd142);
    check_val("t1_total", rpt_bus.rpt_total,      32'd1000);
    check_val("t1_pkts",  rpt_bus.rpt_pkts,       32'd7);
    check_val("t1_seq",   32'(rpt_bus.rpt_seq),   32'd0);

    // Host stalls across two window ends
    pktDelay = 32'd555; pktCount = 32'd5;
    run_to_window_end(); tick();
    run_to_window_end(); tick();
    check_val("t3_drops", 32'(rpt_bus.drop_cnt), 32'd2);
    check_val("t3_avg",   rpt_bus.rpt_avg,       32'd142);
    check_val("t3_seq",   32'(rpt_bus.rpt_seq),  32'd0);
    accept();
    check_val("t3_idle", 32'(rpt_bus.busy), 32'd0);

    // Zero packets: no divide fault
    pktDelay = 32'd0; pktCount = 32'd0;
    capture_and_divide();
    check_val("t2_avg",  rpt_bus.rpt_avg,       32'd0);
    check_val("t2_pkts", rpt_bus.rpt_pkts,      32'd0);
    check_val("t2_seq",  32'(rpt_bus.rpt_seq),  32'd3);

    // Handshake on the window-end edge
    pktDelay = 32'hFFFF_FFFF; pktCount = 32'd1;
    run_to_window_end();
    rpt_bus.rpt_ready = 1'b1;
    tick();
    rpt_bus.rpt_ready = 1'b0;
    check_val("t4_valid", 32'(rpt_bus.rpt_valid), 32'd0);
    check_val("t4_busy",  32'(rpt_bus.busy),      32'd1);
    check_val("t4_drops", 32'(rpt_bus.drop_cnt),  32'd2);
    ticks(LATENCY - 1);
    tick();
    check_val("t4_valid2", 32'(rpt_bus.rpt_valid), 32'd1);
    check_val("t4_seq",    32'(rpt_bus.rpt_seq),   32'd4);
    check_val("t6_max",    rpt_bus.rpt_avg,        32'hFFFF_FFFF);
    accept();

    pktCount = 32'd3;
    capture_and_divide();
    check_val("t6_third", rpt_bus.rpt_avg,       32'h5555_5555);
    check_val("t6_seq",   32'(rpt_bus.rpt_seq),  32'd5);
    accept();

    // Reset in the middle of a division
    pktDelay = 32'd9999; pktCount = 32'd9;
    run_to_window_end();
    tick();
    ticks(15);
    reset = 1'b0;
    #1;
    check_val("t5_valid", 32'(rpt_bus.rpt_valid), 32'd0);
    check_val("t5_drops", 32'(rpt_bus.drop_cnt),  32'd0);
    check_val("t5_busy",  32'(rpt_bus.busy),      32'd0);
    model_reset();
    ticks(3);
    reset = 1'b1;
    capture_and_divide();
    check_val("t5_seq", 32'(rpt_bus.rpt_seq), 32'd0);
    check_val("t5_avg", rpt_bus.rpt_avg,      32'd1111);
    accept();

    // Randomized totals and host readiness
    for (int i = 0; i < 3000; i++) begin
      pktDelay = $urandom;
      case ($urandom_range(0, 3))
        0:       pktCount = 32'd0;
        1:       pktCount = 32'($urandom_range(1, 10));
        2:       pktCount = $urandom;
        default: pktCount = 32'($urandom_range(1, 100000));
      endcase
      rpt_bus.rpt_ready = ($urandom_range(0, 99) < 2);
      if ((count == LIMIT) && ($urandom_range(0, 1) == 1)) rpt_bus.rpt_ready = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
